// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time.
// Optional FETCH_TIMEOUT_EN adds a response watchdog and a sticky fetch_err flag.
module fetch_ctrl #(
    parameter int          n        = 32,
    parameter logic [n-1:0] RESET_PC = '0,
    parameter int          STEP     = 4,
    parameter int          TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_pc,
    output logic         pc_sel,
    output logic         mem_req,
    output logic [n-1:0] mem_addr,
    input  logic         mem_ready,
    input  logic [n-1:0] mem_rdata,
    output logic         instr_valid,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc,
    input  logic         instr_ready,
    output logic         fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_DRAIN
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [n-1:0] r_pc;
    logic [n-1:0] r_instr;
    logic [n-1:0] r_instr_pc;
    logic         r_instr_valid;
    logic         w_redir;
    logic         w_cap;
    logic         w_drop;
    logic         w_tmo;
    logic [n-1:0] w_tgt;
    logic [n-1:0] w_step;

    assign w_redir = reset && redirect_valid && (r_state != S_IDLE);
    assign w_tgt   = {redirect_pc[n-1:2], 2'b00};
    assign w_step  = r_pc + n'(STEP);

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_tmo = ((r_state == S_WAIT) || (r_state == S_DRAIN))
                   && !mem_ready && (r_tmo == TW'(TIMEOUT - 1));

    // Counter restarts on every state change, so WAIT->DRAIN re-arms it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_next != r_state)
                r_tmo <= '0;
            else if ((r_state == S_WAIT) || (r_state == S_DRAIN))
                r_tmo <= r_tmo + 1'b1;
            if (w_tmo)
                r_err <= 1'b1;
        end
    end

    assign fetch_err = r_err;
`else
    assign w_tmo     = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        w_drop = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_REQ;
            S_REQ:  w_next = w_redir ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (mem_ready) begin
                    w_cap  = !w_redir;
                    w_next = w_redir ? S_REQ : S_VALID;
                end else if (w_tmo) begin
                    w_next = S_REQ;
                end else if (w_redir) begin
                    w_next = S_DRAIN;
                end
            end
            S_VALID: begin
                if (w_redir || instr_ready) begin
                    w_drop = 1'b1;
                    w_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (mem_ready || w_tmo)
                    w_next = S_REQ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_redir)
                r_pc <= w_tgt;
            else if (w_cap)
                r_pc <= w_step;
            if (w_cap) begin
                r_instr       <= mem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end else if (w_drop) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign pc_sel      = w_redir;
    assign mem_req     = (r_state == S_REQ);
    assign mem_addr    = (r_state == S_REQ) ? r_pc : '0;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a latency-programmable memory responder.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pc_sel;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_err;

    int passed;
    int total;
    int cyc;
    bit mem_auto;
    int mem_lat;
    bit pend;
    int cnt;
    logic [31:0] paddr;
    logic [31:0] req_addr[$];
    int          req_cyc[$];

    fetch_ctrl #(.n(32), .RESET_PC(32'h0), .STEP(4), .TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .pc_sel(pc_sel),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_req) begin
            req_addr.push_back(mem_addr);
            req_cyc.push_back(cyc);
        end
        if (mem_auto) begin
            if (mem_req) begin
                pend = 1'b1;
                cnt = mem_lat;
                paddr = mem_addr;
                mem_ready = 1'b0;
            end else if (pend && cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = paddr ^ 32'hDEAD_0000;
                pend = 1'b0;
            end else begin
                if (pend) cnt--;
                mem_ready = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_auto = 1'b1;
        mem_lat = 0;
        tick();
        tick();
        pend = 1'b0;
        mem_ready = 1'b0;
        req_addr.delete();
        req_cyc.delete();
    endtask

    task automatic release_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        total++; if (pc_sel !== 1'b0) $display("FAIL rst_pc_sel: got %b want 0", pc_sel); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else passed++;
        total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr); else passed++;
        total++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h want 0", instr_pc); else passed++;
        total++; if (fetch_err !== 1'b0) $display("FAIL rst_err: got %b want 0", fetch_err); else passed++;
        redirect_valid = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] vpc[$];
        logic [31:0] vin[$];
        do_reset();
        release_reset();
        for (int i = 0; i < 11; i++) begin
            if (instr_valid) begin
                vpc.push_back(instr_pc);
                vin.push_back(instr);
            end
            tick();
        end
        if (instr_valid) begin
            vpc.push_back(instr_pc);
            vin.push_back(instr);
        end
        total++; if (req_addr.size() != 4) $display("FAIL seq_nreq: got %0d want 4", req_addr.size()); else passed++;
        total++; if (vpc.size() != 4) $display("FAIL seq_nvalid: got %0d want 4", vpc.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i < req_addr.size()) begin
                total++; if (req_addr[i] !== 32'(4 * i)) $display("FAIL seq_addr%0d: got %h want %h", i, req_addr[i], 32'(4 * i)); else passed++;
            end
            if (i < vpc.size()) begin
                total++; if (vpc[i] !== 32'(4 * i)) $display("FAIL seq_ipc%0d: got %h want %h", i, vpc[i], 32'(4 * i)); else passed++;
                total++; if (vin[i] !== (32'(4 * i) ^ 32'hDEAD_0000)) $display("FAIL seq_instr%0d: got %h want %h", i, vin[i], 32'(4 * i) ^ 32'hDEAD_0000); else passed++;
            end
            if (i > 0 && i < req_cyc.size()) begin
                total++; if (req_cyc[i] - req_cyc[i-1] != 3) $display("FAIL seq_gap%0d: got %0d want 3", i, req_cyc[i] - req_cyc[i-1]); else passed++;
            end
        end
    endtask

    task automatic test_stall();
        int k;
        do_reset();
        instr_ready = 1'b0;
        release_reset();
        k = 0;
        while (!instr_valid && k < 10) begin
            tick();
            k++;
        end
        total++; if (instr_valid !== 1'b1) $display("FAIL stall_timeout: got %b want 1", instr_valid); else passed++;
        req_addr.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD_0000 || instr_pc !== 32'h0 || mem_req !== 1'b0)
                $display("FAIL stall_hold%0d: got v=%b i=%h pc=%h req=%b want v=1 i=dead0000 pc=0 req=0", i, instr_valid, instr, instr_pc, mem_req);
            else passed++;
        end
        instr_ready = 1'b1;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) $display("FAIL stall_next: got req=%b addr=%h want req=1 addr=4", mem_req, mem_addr); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL stall_drop: got %b want 0", instr_valid); else passed++;
    endtask

    task automatic test_redirect_wait();
        int k;
        int sel_cnt;
        bit stale;
        do_reset();
        mem_lat = 3;
        release_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #1;
        sel_cnt = pc_sel ? 1 : 0;
        tick();
        redirect_valid = 1'b0;
        #1;
        stale = 1'b0;
        k = 0;
        while (!mem_req && k < 12) begin
            if (pc_sel) sel_cnt++;
            if (instr_valid) stale = 1'b1;
            tick();
            k++;
        end
        total++; if (stale) $display("FAIL rdw_stale: got instr_valid=1 want 0"); else passed++;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) $display("FAIL rdw_addr: got req=%b addr=%h want req=1 addr=100", mem_req, mem_addr); else passed++;
        k = 0;
        while (!instr_valid && k < 10) begin
            if (pc_sel) sel_cnt++;
            tick();
            k++;
        end
        total++; if (sel_cnt != 1) $display("FAIL rdw_pc_sel: got %0d cycles want 1", sel_cnt); else passed++;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) $display("FAIL rdw_ipc: got v=%b pc=%h want v=1 pc=100", instr_valid, instr_pc); else passed++;
        total++; if (instr !== (32'h100 ^ 32'hDEAD_0000)) $display("FAIL rdw_instr: got %h want %h", instr, 32'h100 ^ 32'hDEAD_0000); else passed++;
    endtask

    task automatic test_redirect_ready();
        do_reset();
        release_reset();
        tick();
        total++; if (mem_ready !== 1'b1) $display("FAIL rdr_setup: got ready=%b want 1", mem_ready); else passed++;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) $display("FAIL rdr_drop: got %b want 0", instr_valid); else passed++;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) $display("FAIL rdr_req: got req=%b addr=%h want req=1 addr=200", mem_req, mem_addr); else passed++;
        tick();
        tick();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) $display("FAIL rdr_ipc: got v=%b pc=%h want v=1 pc=200", instr_valid, instr_pc); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        release_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        total++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL wrap_drain: got req=%b v=%b want 0 0", mem_req, instr_valid); else passed++;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", mem_req, mem_addr); else passed++;
        tick();
        tick();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_ipc: got v=%b pc=%h want v=1 pc=fffffffc", instr_valid, instr_pc); else passed++;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat = 5;
        release_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        reset = 1'b0;
        tick();
        pend = 1'b0;
        mem_ready = 1'b1;
        total++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL mid_clear: got req=%b v=%b want 0 0", mem_req, instr_valid); else passed++;
        reset = 1'b1;
        tick();
        mem_ready = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL mid_pc: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_auto = 1'b0;
        mem_ready = 1'b0;
        release_reset();
        for (int i = 0; i < 16; i++) tick();
        total++; if (mem_req !== 1'b0 || fetch_err !== 1'b0) $display("FAIL tmo_wait16: got req=%b err=%b want 0 0", mem_req, fetch_err); else passed++;
        tick();
`ifdef FETCH_TIMEOUT_EN
        total++; if (fetch_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", fetch_err); else passed++;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL tmo_reissue: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); else passed++;
        for (int i = 0; i < 6; i++) tick();
        total++; if (fetch_err !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", fetch_err); else passed++;
`else
        for (int i = 0; i < 6; i++) tick();
        total++; if (fetch_err !== 1'b0) $display("FAIL tmo_err_off: got %b want 0", fetch_err); else passed++;
        total++; if (req_addr.size() != 1) $display("FAIL tmo_noreissue: got %0d reqs want 1", req_addr.size()); else passed++;
`endif
        reset = 1'b0;
        tick();
        total++; if (fetch_err !== 1'b0) $display("FAIL tmo_clear: got %b want 0", fetch_err); else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        cyc = 0;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        instr_ready = 1'b1;
        mem_auto = 1'b1;
        mem_lat = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ready();
        test_wrap();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
